// File: rtl/pico_out_demux_if.sv
// PicoBlaze OUTPUT write bus plus the update handshake toward the RTC write sequencer.
// slave = demux side, master = PicoBlaze/sequencer side.
interface pico_out_demux_if #(
   parameter int DW     = 8,
   parameter int NUM_CH = 14
);
   logic [3:0]        sel;
   logic              w_s;
   logic [DW-1:0]     dat;
   logic [NUM_CH-1:0] upd_mask;
   logic              upd_req;
   logic              upd_ack;
   logic              busy;
   logic              pend;
   logic              err;

   modport slave (
      input  sel,
      input  w_s,
      input  dat,
      input  upd_ack,
      output upd_mask,
      output upd_req,
      output busy,
      output pend,
      output err
   );

   modport master (
      output sel,
      output w_s,
      output dat,
      output upd_ack,
      input  upd_mask,
      input  upd_req,
      input  busy,
      input  pend,
      input  err
   );
endinterface

// File: rtl/pico_out_demux.sv
// Shadow-banked PicoBlaze output demux with atomic commit and req/ack change notification.
// Optional BCD digit check on data writes: define OUT_BCD_CHECK_EN.
//
// state   | meaning
// IDLE    | no handshake; commits execute immediately (or a queued one runs)
// REQ     | upd_req high, waiting for upd_ack=1
// WAIT_LO | upd_req low, waiting for upd_ack to return to 0
module pico_out_demux #(
   parameter int         NUM_CH       = 14,
   parameter int         DW           = 8,
   parameter logic [3:0] COMMIT_ADDR  = 4'hE,
   parameter logic [3:0] DISCARD_ADDR = 4'hF
) (
   input  logic          clk,
   input  logic          reset,
   pico_out_demux_if.slave bus,
   output logic [DW-1:0] ch0,
   output logic [DW-1:0] ch1,
   output logic [DW-1:0] ch2,
   output logic [DW-1:0] ch3,
   output logic [DW-1:0] ch4,
   output logic [DW-1:0] ch5,
   output logic [DW-1:0] ch6,
   output logic [DW-1:0] ch7,
   output logic [DW-1:0] ch8,
   output logic [DW-1:0] ch9,
   output logic [DW-1:0] ch10,
   output logic [DW-1:0] ch11,
   output logic [DW-1:0] ch12,
   output logic [DW-1:0] ch13
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      WAIT_LO = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [DW-1:0]     sh_q [NUM_CH];
   logic [DW-1:0]     ch_q [NUM_CH];
   logic [NUM_CH-1:0] dirty_q, dirty_d;
   logic [NUM_CH-1:0] mask_q;
   logic              pend_q, pend_d;

   logic data_wr;
   logic commit_wr;
   logic discard_wr;
   logic bcd_ok;
   logic accept;
   logic run_commit;
   logic exec;

   assign data_wr    = bus.w_s && (bus.sel <= 4'(NUM_CH - 1));
   assign commit_wr  = bus.w_s && (bus.sel == COMMIT_ADDR);
   assign discard_wr = bus.w_s && (bus.sel == DISCARD_ADDR);

`ifdef OUT_BCD_CHECK_EN
   logic err_q;

   assign bcd_ok = (bus.dat[3:0] <= 4'd9) && (bus.dat[7:4] <= 4'd9);

   always_ff @(posedge clk) begin
      if (reset) begin
         err_q <= 1'b0;
      end else if (discard_wr) begin
         err_q <= 1'b0;
      end else if (data_wr && !bcd_ok) begin
         err_q <= 1'b1;
      end
   end

   assign bus.err = err_q;
`else
   assign bcd_ok  = 1'b1;
   assign bus.err = 1'b0;
`endif

   assign accept = data_wr && bcd_ok;

   // A discard cancels a queued commit even if it lands on the IDLE cycle.
   assign run_commit = commit_wr || (pend_q && !discard_wr);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      exec    = 1'b0;
      case (state_q)
         IDLE: begin
            if (run_commit && (dirty_q != '0)) begin
               exec    = 1'b1;
               state_d = REQ;
            end
         end
         REQ: begin
            if (bus.upd_ack) begin
               state_d = WAIT_LO;
            end
         end
         WAIT_LO: begin
            if (!bus.upd_ack) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Executing commit consumes the pre-write dirty set; a same-cycle write re-marks its channel.
   always_comb begin
      dirty_d = dirty_q;
      if (exec || discard_wr) begin
         dirty_d = '0;
      end
      for (int i = 0; i < NUM_CH; i++) begin
         if (accept && (bus.sel == i[3:0])) begin
            dirty_d[i] = 1'b1;
         end
      end
   end

   always_comb begin
      pend_d = pend_q;
      if (state_q == IDLE) begin
         pend_d = 1'b0;
      end else if (commit_wr) begin
         pend_d = 1'b1;
      end
      if (discard_wr) begin
         pend_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_CH; i++) begin
            sh_q[i] <= '0;
            ch_q[i] <= '0;
         end
         dirty_q <= '0;
         mask_q  <= '0;
         pend_q  <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (discard_wr) begin
               sh_q[i] <= ch_q[i];
            end else if (accept && (bus.sel == i[3:0])) begin
               sh_q[i] <= bus.dat;
            end
            if (exec && dirty_q[i]) begin
               ch_q[i] <= sh_q[i];
            end
         end
         if (exec) begin
            mask_q <= dirty_q;
         end
         dirty_q <= dirty_d;
         pend_q  <= pend_d;
      end
   end

   assign bus.upd_req  = (state_q == REQ);
   assign bus.busy     = (state_q != IDLE);
   assign bus.pend     = pend_q;
   assign bus.upd_mask = mask_q;

   assign ch0  = ch_q[0];
   assign ch1  = ch_q[1];
   assign ch2  = ch_q[2];
   assign ch3  = ch_q[3];
   assign ch4  = ch_q[4];
   assign ch5  = ch_q[5];
   assign ch6  = ch_q[6];
   assign ch7  = ch_q[7];
   assign ch8  = ch_q[8];
   assign ch9  = ch_q[9];
   assign ch10 = ch_q[10];
   assign ch11 = ch_q[11];
   assign ch12 = ch_q[12];
   assign ch13 = ch_q[13];

endmodule

// File: tb/tb_pico_out_demux.sv
// Directed vector-table bench for pico_out_demux, plus hand sequences for queued-commit corners.
module tb_pico_out_demux;

`ifdef OUT_BCD_CHECK_EN
   localparam logic B = 1'b1;
`else
   localparam logic B = 1'b0;
`endif
   localparam logic        NB  = ~B;
   localparam logic [7:0]  E2  = B ? 8'h00 : 8'h3A;
   localparam logic [13:0] M2  = B ? 14'h0000 : 14'h0004;

   logic       clk;
   logic       reset;
   logic [7:0] ch_arr [14];
   int         checks = 0;
   int         errors = 0;

   pico_out_demux_if bus ();

   pico_out_demux dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus),
      .ch0  (ch_arr[0]),
      .ch1  (ch_arr[1]),
      .ch2  (ch_arr[2]),
      .ch3  (ch_arr[3]),
      .ch4  (ch_arr[4]),
      .ch5  (ch_arr[5]),
      .ch6  (ch_arr[6]),
      .ch7  (ch_arr[7]),
      .ch8  (ch_arr[8]),
      .ch9  (ch_arr[9]),
      .ch10 (ch_arr[10]),
      .ch11 (ch_arr[11]),
      .ch12 (ch_arr[12]),
      .ch13 (ch_arr[13])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        w;
      logic [3:0]  sel;
      logic [7:0]  dat;
      logic        ack;
      int          cch;
      logic [7:0]  ech;
      logic [13:0] emask;
      logic        ereq;
      logic        ebusy;
      logic        epend;
      logic        eerr;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic rst, logic w, logic [3:0] sel, logic [7:0] dat, logic ack,
                               int cch, logic [7:0] ech, logic [13:0] emask,
                               logic ereq, logic ebusy, logic epend, logic eerr);
      vec_t v;
      v.rst = rst; v.w = w; v.sel = sel; v.dat = dat; v.ack = ack;
      v.cch = cch; v.ech = ech; v.emask = emask;
      v.ereq = ereq; v.ebusy = ebusy; v.epend = epend; v.eerr = eerr;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input logic rst, input logic w, input logic [3:0] sel,
                       input logic [7:0] dat, input logic ack);
      @(negedge clk);
      reset       = rst;
      bus.w_s     = w;
      bus.sel     = sel;
      bus.dat     = dat;
      bus.upd_ack = ack;
      @(posedge clk);
      #1;
   endtask

   task automatic finish_hs(input string tag);
      int n;
      n = 0;
      while (bus.upd_req && n < 8) begin
         step(1'b0, 1'b0, 4'h0, 8'h00, 1'b1);
         n++;
      end
      check({tag, "_req_drop"}, 32'(bus.upd_req), 32'd0);
      n = 0;
      while (bus.busy && n < 8) begin
         step(1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
         n++;
      end
      check({tag, "_idle"}, 32'(bus.busy), 32'd0);
   endtask

   initial begin
      reset       = 1'b1;
      bus.w_s     = 1'b0;
      bus.sel     = 4'h0;
      bus.dat     = 8'h00;
      bus.upd_ack = 1'b0;

      //               rst w  sel    dat    ack  cch ech    mask      req busy pend err
      vecs.push_back(mk(1, 0, 4'h0, 8'h00, 0,   3, 8'h00, 14'h0000, 0,  0,   0,   0));
      vecs.push_back(mk(0, 1, 4'h3, 8'h15, 0,   3, 8'h00, 14'h0000, 0,  0,   0,   0));
      vecs.push_back(mk(0, 1, 4'h7, 8'h42, 0,   7, 8'h00, 14'h0000, 0,  0,   0,   0));
      vecs.push_back(mk(0, 1, 4'hE, 8'h00, 0,   3, 8'h15, 14'h0088, 1,  1,   0,   0));
      vecs.push_back(mk(0, 0, 4'h0, 8'h00, 0,   7, 8'h42, 14'h0088, 1,  1,   0,   0));
      vecs.push_back(mk(0, 0, 4'h0, 8'h00, 0,   0, 8'h00, 14'h0088, 1,  1,   0,   0));
      vecs.push_back(mk(0, 0, 4'h0, 8'h00, 1,   3, 8'h15, 14'h0088, 0,  1,   0,   0));
      vecs.push_back(mk(0, 0, 4'h0, 8'h00, 1,   3, 8'h15, 14'h0088, 0,  1,   0,   0));
      vecs.push_back(mk(0, 0, 4'h0, 8'h00, 0,   7, 8'h42, 14'h0088, 0,  0,   0,   0));
      // write then discard: a following commit has nothing to send
      vecs.push_back(mk(0, 1, 4'h0, 8'h30, 0,   0, 8'h00, 14'h0088, 0,  0,   0,   0));
      vecs.push_back(mk(0, 1, 4'hF, 8'h00, 0,   0, 8'h00, 14'h0088, 0,  0,   0,   0));
      vecs.push_back(mk(0, 1, 4'hE, 8'h00, 0,   0, 8'h00, 14'h0088, 0,  0,   0,   0));
      // commits during REQ queue one-deep
      vecs.push_back(mk(0, 1, 4'h5, 8'h07, 0,   5, 8'h00, 14'h0088, 0,  0,   0,   0));
      vecs.push_back(mk(0, 1, 4'hE, 8'h00, 0,   5, 8'h07, 14'h0020, 1,  1,   0,   0));
      vecs.push_back(mk(0, 1, 4'h1, 8'h59, 0,   1, 8'h00, 14'h0020, 1,  1,   0,   0));
      vecs.push_back(mk(0, 1, 4'hE, 8'h00, 0,   1, 8'h00, 14'h0020, 1,  1,   1,   0));
      vecs.push_back(mk(0, 1, 4'hE, 8'h00, 0,   1, 8'h00, 14'h0020, 1,  1,   1,   0));
      vecs.push_back(mk(0, 0, 4'h0, 8'h00, 1,   1, 8'h00, 14'h0020, 0,  1,   1,   0));
      vecs.push_back(mk(0, 0, 4'h0, 8'h00, 0,   1, 8'h00, 14'h0020, 0,  0,   1,   0));
      vecs.push_back(mk(0, 0, 4'h0, 8'h00, 0,   1, 8'h59, 14'h0002, 1,  1,   0,   0));
      vecs.push_back(mk(0, 0, 4'h0, 8'h00, 1,   1, 8'h59, 14'h0002, 0,  1,   0,   0));
      vecs.push_back(mk(0, 0, 4'h0, 8'h00, 0,   3, 8'h15, 14'h0002, 0,  0,   0,   0));
      // ack in IDLE ignored; minimum two-cycle handshake
      vecs.push_back(mk(0, 1, 4'h4, 8'h44, 1,   4, 8'h00, 14'h0002, 0,  0,   0,   0));
      vecs.push_back(mk(0, 1, 4'hE, 8'h00, 1,   4, 8'h44, 14'h0010, 1,  1,   0,   0));
      vecs.push_back(mk(0, 0, 4'h0, 8'h00, 1,   4, 8'h44, 14'h0010, 0,  1,   0,   0));
      vecs.push_back(mk(0, 0, 4'h0, 8'h00, 0,   4, 8'h44, 14'h0010, 0,  0,   0,   0));
      // reset mid-handshake with a pending commit
      vecs.push_back(mk(0, 1, 4'h9, 8'h11, 0,   9, 8'h00, 14'h0010, 0,  0,   0,   0));
      vecs.push_back(mk(0, 1, 4'hE, 8'h00, 0,   9, 8'h11, 14'h0200, 1,  1,   0,   0));
      vecs.push_back(mk(0, 1, 4'hE, 8'h00, 0,   9, 8'h11, 14'h0200, 1,  1,   1,   0));
      vecs.push_back(mk(1, 0, 4'h0, 8'h00, 0,   9, 8'h00, 14'h0000, 0,  0,   0,   0));
      vecs.push_back(mk(0, 0, 4'h0, 8'h00, 1,   3, 8'h00, 14'h0000, 0,  0,   0,   0));
      vecs.push_back(mk(0, 1, 4'hE, 8'h00, 0,   3, 8'h00, 14'h0000, 0,  0,   0,   0));
      // non-BCD byte: rejected with err when the check is built in
      vecs.push_back(mk(0, 1, 4'h2, 8'h3A, 0,   2, 8'h00, 14'h0000, 0,  0,   0,   B));
      vecs.push_back(mk(0, 1, 4'hE, 8'h00, 0,   2, E2,    M2,       NB, NB,  0,   B));
      vecs.push_back(mk(0, 0, 4'h0, 8'h00, 1,   2, E2,    M2,       0,  NB,  0,   B));
      vecs.push_back(mk(0, 0, 4'h0, 8'h00, 0,   2, E2,    M2,       0,  0,   0,   B));
      vecs.push_back(mk(0, 1, 4'h2, 8'h23, 0,   2, E2,    M2,       0,  0,   0,   B));
      vecs.push_back(mk(0, 1, 4'hE, 8'h00, 0,   2, 8'h23, 14'h0004, 1,  1,   0,   B));
      vecs.push_back(mk(0, 1, 4'hF, 8'h00, 0,   2, 8'h23, 14'h0004, 1,  1,   0,   0));
      vecs.push_back(mk(0, 0, 4'h0, 8'h00, 1,   2, 8'h23, 14'h0004, 0,  1,   0,   0));
      vecs.push_back(mk(0, 0, 4'h0, 8'h00, 0,   2, 8'h23, 14'h0004, 0,  0,   0,   0));

      for (int k = 0; k < vecs.size(); k++) begin
         step(vecs[k].rst, vecs[k].w, vecs[k].sel, vecs[k].dat, vecs[k].ack);
         check($sformatf("v%0d_ch%0d", k, vecs[k].cch), 32'(ch_arr[vecs[k].cch]), 32'(vecs[k].ech));
         check($sformatf("v%0d_mask", k), 32'(bus.upd_mask), 32'(vecs[k].emask));
         check($sformatf("v%0d_req", k),  32'(bus.upd_req),  32'(vecs[k].ereq));
         check($sformatf("v%0d_busy", k), 32'(bus.busy),     32'(vecs[k].ebusy));
         check($sformatf("v%0d_pend", k), 32'(bus.pend),     32'(vecs[k].epend));
         check($sformatf("v%0d_err", k),  32'(bus.err),      32'(vecs[k].eerr));
      end

      // Queued commit runs on the same IDLE cycle as a data write: write stays dirty.
      step(1'b0, 1'b1, 4'h6, 8'h06, 1'b0);
      step(1'b0, 1'b1, 4'hE, 8'h00, 1'b0);
      check("q_mask1", 32'(bus.upd_mask), 32'h0040);
      check("q_req1", 32'(bus.upd_req), 32'd1);
      step(1'b0, 1'b1, 4'h8, 8'h08, 1'b0);
      step(1'b0, 1'b1, 4'hE, 8'h00, 1'b0);
      check("q_pend", 32'(bus.pend), 32'd1);
      step(1'b0, 1'b0, 4'h0, 8'h00, 1'b1);
      step(1'b0, 1'b0, 4'h0, 8'h00, 1'b0);
      check("q_idle_busy", 32'(bus.busy), 32'd0);
      check("q_idle_pend", 32'(bus.pend), 32'd1);
      check("q_ch8_held", 32'(ch_arr[8]), 32'h00);
      step(1'b0, 1'b1, 4'hA, 8'h10, 1'b0);
      check("q_exec_req", 32'(bus.upd_req), 32'd1);
      check("q_exec_mask", 32'(bus.upd_mask), 32'h0100);
      check("q_exec_ch8", 32'(ch_arr[8]), 32'h08);
      check("q_exec_ch10", 32'(ch_arr[10]), 32'h00);
      check("q_exec_pend", 32'(bus.pend), 32'd0);
      finish_hs("q_hs1");
      step(1'b0, 1'b1, 4'hE, 8'h00, 1'b0);
      check("q2_mask", 32'(bus.upd_mask), 32'h0400);
      check("q2_ch10", 32'(ch_arr[10]), 32'h10);
      check("q2_ch6", 32'(ch_arr[6]), 32'h06);
      finish_hs("q_hs2");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pico_out_demux.md
Name: pico_out_demux

Overview:
- Output-side counterpart of the PicoBlaze input selector in the RTC controller.
- Captures PicoBlaze OUTPUT writes, addressed by the port_id low nibble, into a 14-channel shadow bank of 8-bit registers.
- A commit write atomically transfers the shadow bank to the visible channel outputs.
- After a commit, a four-phase req/ack handshake tells the RTC write sequencer which channels changed.

Parameters:
NUM_CH, 14, number of data channels (fixed at 14 in this design; addresses 0x0–0xD)
DW, 8, channel data width
COMMIT_ADDR, 4'hE, sel value that commits the shadow bank
DISCARD_ADDR, 4'hF, sel value that discards pending shadow writes

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
sel  input  4  port_id[3:0] from PicoBlaze
w_s  input  1  write strobe; one-cycle pulse per OUTPUT
dat  input  8  out_port data
ch0..ch13  output  8 each  committed channel values
upd_mask  output  14  channels changed by the last commit; bit i = ch i
upd_req  output  1  update request to RTC sequencer
upd_ack  input  1  acknowledge from RTC sequencer
busy  output  1  high while a handshake is in progress
pend  output  1  a commit is queued behind the active handshake
err  output  1  sticky reject flag (see Optional Feature)

Behaviour:
- Reset: all sh[i], ch[i], dirty, upd_mask, upd_req, pend and err are 0; FSM goes to IDLE. Reset applies mid-handshake with no completion.
- Data write (w_s=1, sel<=0xD), cycle n: sh[sel]<=dat and dirty[sel]<=1 at the n+1 edge. ch outputs are unchanged. Allowed in any state.
- Writes with w_s=0 are ignored. Writes to sel 0xE/0xF never touch sh.
- Commit (w_s=1, sel=COMMIT_ADDR) in IDLE at cycle n, effective at edge n+1:
  - ch[i]<=sh[i] for every i with dirty[i]=1; other ch[i] unchanged.
  - upd_mask<=dirty; dirty<=0; upd_req<=1; state goes to REQ.
- Commit with dirty=0: no handshake, no state change.
- Commit while busy:
  - sets pend=1 (one-deep; further commits are absorbed).
  - The queued commit executes on the first IDLE cycle, using dirty at that time. If dirty is then 0, pend just clears.
- Discard (w_s=1, sel=DISCARD_ADDR): sh[i]<=ch[i] for all i; dirty<=0; pend<=0; err<=0. The active handshake is unaffected.
- FSM (busy = state!=IDLE):
  - IDLE: on a commit as above, go to REQ.
  - REQ: upd_req=1. When upd_ack=1 is sampled, upd_req<=0 and go to WAIT_LO.
  - WAIT_LO: when upd_ack=0 is sampled, go to IDLE.
  - upd_ack=1 seen in IDLE is ignored.
- upd_mask and ch outputs are stable from the commit edge until the next commit executes.
- Minimum handshake: 2 cycles from REQ entry (ack already high) back to IDLE.
- Data write and queued-commit execution in the same cycle: the queued commit uses the pre-write dirty and sh. The written channel stays dirty for the next commit.

Optional Feature:
- Macro OUT_BCD_CHECK_EN.
- Defined:
  - A data write with dat[3:0]>9 or dat[7:4]>9 is rejected: sh and dirty are unchanged, and err<=1 (sticky).
  - err clears only on reset or discard.
- Undefined: all data writes are accepted and err is tied to 0.

Test Plan:
- Reset; write 0x15 to ch3 and 0x42 to ch7; commit; ack after 3 cycles → ch3=0x15 and ch7=0x42 one cycle after the commit strobe; others 0; upd_mask=0x0088; upd_req high until ack, then busy drops one cycle after ack falls.
- Write 0x30 to ch0, then discard → sh0 reverts to ch0; a following commit raises no upd_req.
- During REQ, write 0x59 to ch1 and commit twice → pend=1; ch1 is unchanged until the handshake completes; the next IDLE starts a new REQ with upd_mask=0x0002.
- Assert reset while in REQ → upd_req, busy, pend, all ch and upd_mask are 0 on the next cycle.
- With OUT_BCD_CHECK_EN, write 0x3A to ch2 → ch2 is not dirty and err=1; writing 0x23 is then accepted; discard clears err. Without the macro, 0x3A is accepted and err=0.
